cc_input_loader: RTL and testbench

//  Front-end stage directly upstream of the Candy Crush engine (CC).

---
 rtl/cc_pkg.sv | 37 +++
 rtl/cc_ffz36.sv | 21 ++
 rtl/cc_input_loader.sv | 190 +++++++++++++++++++
 tb/tb_cc_input_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared constants and types for the Candy Crush input loader.
// Board geometry, frame sizes, FSM state codes and beat payload layouts.
package cc_pkg;

    localparam int ROWS     = 6;
    localparam int COLS     = 6;
    localparam int N_CELLS  = ROWS * COLS;
    localparam int N_PLACED = 4;
    localparam int N_FILL   = N_CELLS - N_PLACED;
    localparam int N_ACT    = 10;
    localparam int COLOR_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLACE = 3'd1,
        ST_FILL  = 3'd2,
        ST_GAP   = 3'd3,
        ST_ACT   = 3'd4,
        ST_SERVE = 3'd5
    } state_e;

    // Matches the in_starting_pos wire layout {x[5:3], y[2:0]}.
    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } pos_t;

    typedef struct packed {
        logic [1:0] code;
        pos_t       pos;
    } action_t;

    function automatic logic [5:0] cell_index(input pos_t p);
        return 6'(int'(p.y) * COLS + int'(p.x));
    endfunction

endpackage

// File: rtl/cc_ffz36.sv
// 36-bit find-first-zero: index of the lowest clear bit of mask,
// with none_free raised when every bit is set.
import cc_pkg::*;

module cc_ffz36 (
    input  logic [N_CELLS-1:0] mask,
    output logic [5:0]         idx,
    output logic               none_free
);

    // Scan high to low so the lowest clear bit is the last assignment.
    always_comb begin
        idx = '0;
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (!mask[i]) idx = 6'(i);
        end
    end

    assign none_free = &mask;

endmodule

// File: rtl/cc_input_loader.sv
// Deserialises the two-phase input stream into a 6x6 board and a 10-deep action queue.
// Define CC_LOADER_ERRCHK_EN to build the sticky protocol-error flag.
import cc_pkg::*;

module cc_input_loader (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_1,
    input  logic                       in_valid_2,
    input  logic [COLOR_W-1:0]         in_color,
    input  logic                       in_stripe,
    input  logic [1:0]                 in_action,
    input  logic [5:0]                 in_starting_pos,
    output logic                       board_valid,
    output logic [N_CELLS*COLOR_W-1:0] board_color,
    output logic [N_CELLS-1:0]         board_stripe,
    output logic                       act_valid,
    output logic [1:0]                 act_code,
    output logic [5:0]                 act_pos,
    input  logic                       act_ready,
    input  logic                       frame_done,
    output logic                       err
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_PLACE = ST_PLACE;
    localparam logic [2:0] S_FILL  = ST_FILL;
    localparam logic [2:0] S_GAP   = ST_GAP;
    localparam logic [2:0] S_ACT   = ST_ACT;
    localparam logic [2:0] S_SERVE = ST_SERVE;

    logic [2:0]                 state;
    logic [4:0]                 beat_cnt;
    logic [N_CELLS*COLOR_W-1:0] color_q;
    logic [N_CELLS-1:0]         stripe_q;
    logic [N_CELLS-1:0]         occ_q;
    action_t                    queue_q [N_ACT];
    logic [3:0]                 q_cnt;

    logic    [5:0] free_idx;
    logic          none_free;
    pos_t          in_pos;
    logic          pos_ok;
    logic    [5:0] pos_idx;
    action_t       in_act;
    logic          pop;

    cc_ffz36 u_ffz (
        .mask      (occ_q),
        .idx       (free_idx),
        .none_free (none_free)
    );

    assign in_pos  = pos_t'(in_starting_pos);
    assign pos_ok  = (in_pos.x < 3'(COLS)) && (in_pos.y < 3'(ROWS));
    assign pos_idx = cell_index(in_pos);
    assign in_act  = '{code: in_action, pos: in_pos};

    // act_valid/act_ready: the head transfers on any cycle both are high.
    // act_valid never depends on act_ready, and the head holds until popped.
    assign board_valid  = (state == S_SERVE);
    assign act_valid    = board_valid && (q_cnt != 4'd0);
    assign act_code     = queue_q[0].code;
    assign act_pos      = queue_q[0].pos;
    assign pop          = act_valid && act_ready;
    assign board_color  = color_q;
    assign board_stripe = stripe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            color_q  <= '0;
            stripe_q <= '0;
            occ_q    <= '0;
            q_cnt    <= '0;
            for (int i = 0; i < N_ACT; i++) queue_q[i] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid_1) begin
                        // Clear first; the placed-beat write below overrides its cell.
                        color_q  <= '0;
                        stripe_q <= '0;
                        occ_q    <= '0;
                        q_cnt    <= '0;
                        if (pos_ok) begin
                            color_q[int'(pos_idx)*COLOR_W +: COLOR_W] <= in_color;
                            stripe_q[pos_idx] <= in_stripe;
                            occ_q[pos_idx]    <= 1'b1;
                        end
                        beat_cnt <= 5'd1;
                        state    <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    if (!in_valid_1) begin
                        state <= S_IDLE;
                    end else begin
                        if (pos_ok) begin
                            color_q[int'(pos_idx)*COLOR_W +: COLOR_W] <= in_color;
                            stripe_q[pos_idx] <= in_stripe;
                            occ_q[pos_idx]    <= 1'b1;
                        end
                        if (beat_cnt == 5'(N_PLACED - 1)) begin
                            beat_cnt <= '0;
                            state    <= S_FILL;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (!in_valid_1) begin
                        state <= S_IDLE;
                    end else begin
                        if (!none_free) begin
                            color_q[int'(free_idx)*COLOR_W +: COLOR_W] <= in_color;
                            stripe_q[free_idx] <= 1'b0;
                            occ_q[free_idx]    <= 1'b1;
                        end
                        if (beat_cnt == 5'(N_FILL - 1)) begin
                            beat_cnt <= '0;
                            state    <= S_GAP;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (in_valid_2) begin
                        queue_q[0] <= in_act;
                        q_cnt      <= 4'd1;
                        state      <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (!in_valid_2) begin
                        state <= S_IDLE;
                    end else begin
                        queue_q[q_cnt] <= in_act;
                        q_cnt          <= q_cnt + 4'd1;
                        if (q_cnt == 4'(N_ACT - 1)) state <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (frame_done) begin
                        state <= S_IDLE;
                        q_cnt <= '0;
                        for (int i = 0; i < N_ACT; i++) queue_q[i] <= '0;
                    end else if (pop) begin
                        for (int i = 0; i < N_ACT - 1; i++) queue_q[i] <= queue_q[i+1];
                        queue_q[N_ACT-1] <= '0;
                        q_cnt <= q_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CC_LOADER_ERRCHK_EN
    logic err_q;
    logic err_set;

    always_comb begin
        err_set = in_valid_1 && in_valid_2;
        unique case (state)
            S_IDLE:  if (in_valid_1 && !pos_ok) err_set = 1'b1;
            S_PLACE: if (!in_valid_1 || !pos_ok || occ_q[pos_idx]) err_set = 1'b1;
            S_FILL:  if (!in_valid_1) err_set = 1'b1;
            S_ACT:   if (!in_valid_2) err_set = 1'b1;
            S_SERVE: if (in_valid_1 || in_valid_2) err_set = 1'b1;
            default: ;
        endcase
    end

    // A new frame clears the flag, but an error on that same beat still wins.
    always_ff @(posedge clk) begin
        if (rst)                             err_q <= 1'b0;
        else if (err_set)                    err_q <= 1'b1;
        else if (state == S_IDLE && in_valid_1) err_q <= 1'b0;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cc_input_loader.sv
// Directed bench for cc_input_loader: a frame-level board/queue model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_cc_input_loader;

`ifdef CC_LOADER_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid_1 = 1'b0;
    logic         in_valid_2 = 1'b0;
    logic [2:0]   in_color = '0;
    logic         in_stripe = 1'b0;
    logic [1:0]   in_action = '0;
    logic [5:0]   in_starting_pos = '0;
    logic         board_valid;
    logic [107:0] board_color;
    logic [35:0]  board_stripe;
    logic         act_valid;
    logic [1:0]   act_code;
    logic [5:0]   act_pos;
    logic         act_ready = 1'b0;
    logic         frame_done = 1'b0;
    logic         err;

    always #5 clk = ~clk;

    cc_input_loader dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_1      (in_valid_1),
        .in_valid_2      (in_valid_2),
        .in_color        (in_color),
        .in_stripe       (in_stripe),
        .in_action       (in_action),
        .in_starting_pos (in_starting_pos),
        .board_valid     (board_valid),
        .board_color     (board_color),
        .board_stripe    (board_stripe),
        .act_valid       (act_valid),
        .act_code        (act_code),
        .act_pos         (act_pos),
        .act_ready       (act_ready),
        .frame_done      (frame_done),
        .err             (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Frame stimulus tables and the expected state derived from them.
    logic [5:0]   pl_pos   [4];
    logic [2:0]   pl_col   [4];
    logic         pl_str   [4];
    logic [2:0]   fill_col [32];
    logic [1:0]   ac_code  [10];
    logic [5:0]   ac_pos   [10];
    logic [7:0]   exp_q[$];
    bit           exp_bv  = 1'b0;
    bit           exp_err = 1'b0;
    bit           mon_en  = 1'b0;
    logic [107:0] exp_color;
    logic [35:0]  exp_stripe;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic bit in_range(input logic [5:0] p);
        return (p[5:3] < 3'd6) && (p[2:0] < 3'd6);
    endfunction

    // Board as the rules define it: placed cells first, then each fill colour
    // goes to the lowest-numbered cell nobody has claimed yet.
    task automatic build_model();
        bit occ [36];
        int col [36];
        bit str [36];
        for (int i = 0; i < 36; i++) begin occ[i] = 0; col[i] = 0; str[i] = 0; end
        for (int p = 0; p < 4; p++) begin
            if (in_range(pl_pos[p])) begin
                int c;
                c = int'(pl_pos[p][2:0]) * 6 + int'(pl_pos[p][5:3]);
                col[c] = int'(pl_col[p]);
                str[c] = pl_str[p];
                occ[c] = 1;
            end
        end
        for (int f = 0; f < 32; f++) begin
            for (int i = 0; i < 36; i++) begin
                if (!occ[i]) begin col[i] = int'(fill_col[f]); occ[i] = 1; break; end
            end
        end
        for (int i = 0; i < 36; i++) begin
            exp_color[i*3 +: 3] = 3'(col[i]);
            exp_stripe[i]       = str[i];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_board_valid"}, board_valid, 1'b0);
        check({tag, "_board_color"}, board_color, 108'd0);
        check({tag, "_board_stripe"}, board_stripe, 36'd0);
        check({tag, "_act_valid"}, act_valid, 1'b0);
        check({tag, "_act_code"}, act_code, 2'd0);
        check({tag, "_act_pos"}, act_pos, 6'd0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    task automatic drive_board(input int nbeats);
        build_model();
        for (int b = 0; b < nbeats; b++) begin
            bit bad;
            in_valid_1 = 1'b1;
            if (b < 4) begin
                in_color = pl_col[b]; in_stripe = pl_str[b]; in_starting_pos = pl_pos[b];
            end else begin
                in_color = fill_col[b-4]; in_stripe = 1'b0; in_starting_pos = '0;
            end
            bad = 0;
            if (b < 4) begin
                if (!in_range(pl_pos[b])) bad = 1;
                for (int j = 0; j < b; j++) if (in_range(pl_pos[b]) && pl_pos[j] == pl_pos[b]) bad = 1;
            end
            @(posedge clk); #1;
            if (b == 0) exp_err = 1'b0;
            exp_err = exp_err | (ERRCHK & bad);
        end
        in_valid_1 = 1'b0;
        if (nbeats < 36) begin
            @(posedge clk); #1;
            exp_err = exp_err | ERRCHK;
        end
    endtask

    task automatic drive_actions(input int nbeats, input int rst_beat);
        for (int a = 0; a < nbeats; a++) begin
            in_valid_2 = 1'b1; in_action = ac_code[a]; in_starting_pos = ac_pos[a];
            if (a == rst_beat) begin
                rst = 1'b1;
                @(posedge clk); #1;
                in_valid_2 = 1'b0;
                exp_err = 1'b0; exp_bv = 1'b0; exp_q.delete();
                check_reset_outputs("mid_rst");
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid_2 = 1'b0;
        if (nbeats == 10) begin
            exp_q.delete();
            for (int a = 0; a < 10; a++) exp_q.push_back({ac_code[a], ac_pos[a]});
            exp_bv = 1'b1;
        end else begin
            @(posedge clk); #1;
            exp_err = exp_err | ERRCHK;
        end
    endtask

    task automatic frame_end();
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        exp_bv = 1'b0;
        exp_q.delete();
    endtask

    // Per-cycle comparison against the model; the model pops when the handshake completes.
    always @(negedge clk) begin
        if (mon_en) begin
            check("board_valid", board_valid, exp_bv);
            check("err", err, exp_err);
            if (exp_bv) begin
                check("act_valid", act_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) check("act_head", {act_code, act_pos}, exp_q[0]);
                check("board_color", board_color, exp_color);
                check("board_stripe", board_stripe, exp_stripe);
                if (exp_q.size() != 0 && act_ready) void'(exp_q.pop_front());
            end else begin
                check("act_valid_off", act_valid, 1'b0);
            end
        end
    end

    task automatic set_board_std();
        pl_pos[0] = {3'd0, 3'd0}; pl_col[0] = 3'd5; pl_str[0] = 1'b1;
        pl_pos[1] = {3'd5, 3'd5}; pl_col[1] = 3'd2; pl_str[1] = 1'b1;
        pl_pos[2] = {3'd1, 3'd0}; pl_col[2] = 3'd3; pl_str[2] = 1'b0;
        pl_pos[3] = {3'd0, 3'd1}; pl_col[3] = 3'd4; pl_str[3] = 1'b0;
        for (int f = 0; f < 32; f++) fill_col[f] = 3'((f + 1) % 6);
    endtask

    task automatic set_actions(input int k);
        for (int i = 0; i < 10; i++) begin
            ac_code[i] = 2'((i * k + k - 1) % 4);
            ac_pos[i]  = {3'(i % 6), 3'((i + k) % 6)};
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Standard board, actions 0,1,2,3,... with ready held from the start.
        set_board_std();
        set_actions(1);
        act_ready = 1'b1;
        drive_board(36);
        drive_actions(10, -1);
        check("t1_bv_latency", board_valid, 1'b1);
        check("t1_cell0", board_color[2:0], 3'd5);
        check("t1_cell1", board_color[5:3], 3'd3);
        check("t1_cell2", board_color[8:6], 3'd1);
        check("t1_cell6", board_color[20:18], 3'd4);
        check("t1_cell35", board_color[107:105], 3'd2);
        check("t1_stripes", board_stripe, 36'h8_0000_0001);
        check("t1_model_stripes", exp_stripe, 36'h8_0000_0001);
        check("t2_first_code", act_code, 2'd0);
        repeat (9) @(posedge clk);
        #1;
        check("t2_tenth_code", act_code, 2'd1);
        check("t2_tenth_valid", act_valid, 1'b1);
        @(posedge clk); #1;
        check("t2_drained", act_valid, 1'b0);
        check("t2_bv_held", board_valid, 1'b1);
        frame_end();

        // Ready alternating 1,0,1,...; then a stray beat during SERVE.
        act_ready = 1'b0;
        set_actions(3);
        drive_board(36);
        drive_actions(10, -1);
        for (int c = 0; c < 24; c++) begin
            act_ready = (c % 2 == 0);
            @(posedge clk); #1;
        end
        act_ready = 1'b0;
        check("t3_drained", act_valid, 1'b0);
        in_valid_2 = 1'b1;
        @(posedge clk); #1;
        in_valid_2 = 1'b0;
        exp_err = exp_err | ERRCHK;
        check("t3_serve_beat_bv", board_valid, 1'b1);
        frame_end();

        // Short in_valid_1 burst, then a good frame.
        drive_board(20);
        repeat (2) @(posedge clk);
        #1;
        check("t4_err", err, ERRCHK);
        check("t4_no_bv", board_valid, 1'b0);
        set_actions(2);
        act_ready = 1'b1;
        drive_board(36);
        drive_actions(10, -1);
        check("t4_recovered_bv", board_valid, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        frame_end();

        // Reset during action beat 5, then a fresh frame with a stray frame_done in GAP.
        drive_board(36);
        drive_actions(10, 5);
        for (int f = 0; f < 32; f++) fill_col[f] = 3'((f % 7) + 1);
        drive_board(36);
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        drive_actions(10, -1);
        check("t5_cell2", board_color[8:6], 3'd1);
        repeat (12) @(posedge clk);
        #1;
        frame_end();

        // Duplicate (2,3) placements plus an out-of-range (7,1) beat.
        pl_pos[0] = {3'd2, 3'd3}; pl_col[0] = 3'd1; pl_str[0] = 1'b0;
        pl_pos[1] = {3'd2, 3'd3}; pl_col[1] = 3'd6; pl_str[1] = 1'b1;
        pl_pos[2] = {3'd0, 3'd0}; pl_col[2] = 3'd2; pl_str[2] = 1'b0;
        pl_pos[3] = {3'd7, 3'd1}; pl_col[3] = 3'd5; pl_str[3] = 1'b0;
        drive_board(36);
        drive_actions(10, -1);
        check("t6_cell20", board_color[62:60], 3'd6);
        check("t6_stripe20", board_stripe[20], 1'b1);
        check("t6_cell34", board_color[104:102], 3'd0);
        check("t6_cell35", board_color[107:105], 3'd0);
        check("t6_err", err, ERRCHK);
        repeat (12) @(posedge clk);
        #1;
        frame_end();
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
